key_search_ctrl: RTL and testbench

//  Initiator for decryption_core's start/done handshake: sweeps the candidate key space, resets and launches the core once per key, and collects the core's key verdict.

---
 rtl/key_search_ctrl_if.sv | 35 +++
 rtl/key_search_ctrl.sv | 152 +++++++++++++++
 tb/tb_key_search_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/key_search_ctrl_if.sv
// Bundle of the key search controller's signals: the top-level control side
// (start request, status flags, result key) and the decryption core
// start/done handshake side.
interface key_search_ctrl_if #(
  parameter int KEY_W = 10
);
  // Top-level control side
  logic             search_start;
  logic             busy;
  logic             found;
  logic             exhausted;
  logic             timeout_err;
  logic [KEY_W-1:0] found_key;

  // Decryption core side
  logic             core_reset_n;
  logic             core_start;
  logic [KEY_W-1:0] core_key;
  logic             core_done;
  logic             core_key_ok;

  // The search controller drives the core and reports status
  modport master (
    input  search_start, core_done, core_key_ok,
    output busy, found, exhausted, timeout_err, found_key,
           core_reset_n, core_start, core_key
  );

  // The environment: top-level control plus the decryption core
  modport slave (
    output search_start, core_done, core_key_ok,
    input  busy, found, exhausted, timeout_err, found_key,
           core_reset_n, core_start, core_key
  );
endinterface

// File: rtl/key_search_ctrl.sv
// Key search controller: sweeps candidate keys from KEY_FIRST to KEY_LAST,
// resetting and launching a single decryption core once per key. The sweep
// stops on the first key the core accepts or when the range runs out, and a
// watchdog reports a core that never finishes. All outputs are registered.
module key_search_ctrl #(
  parameter int KEY_W      = 10,
  parameter int KEY_FIRST  = 0,
  parameter int KEY_LAST   = 2**KEY_W-1,
  parameter int RST_CYCLES = 2,
  parameter int TIMEOUT    = 65535
) (
  input  logic              clk,
  input  logic              reset_n,
  key_search_ctrl_if.master bus
);

  localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  localparam logic [KEY_W-1:0] FIRST_K   = KEY_W'(KEY_FIRST);
  localparam logic [KEY_W-1:0] LAST_K    = KEY_W'(KEY_LAST);
  localparam logic [RC_W-1:0]  RC_LAST   = RC_W'(RST_CYCLES - 1);
  localparam logic [WD_W-1:0]  WD_LAST   = WD_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CORE_RST,
    S_LAUNCH,
    S_WAIT,
    S_CHECK,
    S_HALT
  } state_t;

  state_t           r_state;
  logic             r_start_q;
  logic             r_core_reset_n;
  logic             r_core_start;
  logic [KEY_W-1:0] r_core_key;
  logic             r_busy;
  logic             r_found;
  logic             r_exhausted;
  logic             r_timeout_err;
  logic [KEY_W-1:0] r_found_key;
  logic [RC_W-1:0]  r_rst_cnt;
  logic [WD_W-1:0]  r_wd;
  logic             r_key_ok;

  logic             w_start_edge;

  // A search begins only on a rising edge of the start level
  assign w_start_edge = bus.search_start & ~r_start_q;

  assign bus.core_reset_n = r_core_reset_n;
  assign bus.core_start   = r_core_start;
  assign bus.core_key     = r_core_key;
  assign bus.busy         = r_busy;
  assign bus.found        = r_found;
  assign bus.exhausted    = r_exhausted;
  assign bus.timeout_err  = r_timeout_err;
  assign bus.found_key    = r_found_key;

  // Sweep sequencer: reset core, launch it, wait for its verdict, step the key
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= S_IDLE;
      r_start_q      <= 1'b0;
      r_core_reset_n <= 1'b0;
      r_core_start   <= 1'b0;
      r_core_key     <= FIRST_K;
      r_busy         <= 1'b0;
      r_found        <= 1'b0;
      r_exhausted    <= 1'b0;
      r_timeout_err  <= 1'b0;
      r_found_key    <= '0;
      r_rst_cnt      <= '0;
      r_wd           <= '0;
      r_key_ok       <= 1'b0;
    end else begin
      r_start_q    <= bus.search_start;
      r_core_start <= 1'b0;

      case (r_state)
        S_IDLE, S_HALT: begin
          r_core_reset_n <= 1'b0;
          if (w_start_edge) begin
            r_core_key    <= FIRST_K;
            r_found       <= 1'b0;
            r_exhausted   <= 1'b0;
            r_timeout_err <= 1'b0;
            r_busy        <= 1'b1;
            r_rst_cnt     <= '0;
            r_state       <= S_CORE_RST;
          end
        end

        S_CORE_RST: begin
          r_core_reset_n <= 1'b0;
          r_rst_cnt      <= r_rst_cnt + 1'b1;
          if (r_rst_cnt == RC_LAST) begin
            r_core_reset_n <= 1'b1;
            r_state        <= S_LAUNCH;
          end
        end

        S_LAUNCH: begin
          r_core_reset_n <= 1'b1;
          r_core_start   <= 1'b1;
          r_wd           <= '0;
          r_state        <= S_WAIT;
        end

        S_WAIT: begin
          if (bus.core_done) begin
            r_key_ok <= bus.core_key_ok;
            r_state  <= S_CHECK;
          end else if (r_wd == WD_LAST) begin
            r_timeout_err  <= 1'b1;
            r_busy         <= 1'b0;
            r_core_reset_n <= 1'b0;
            r_state        <= S_HALT;
          end else begin
            r_wd <= r_wd + 1'b1;
          end
        end

        S_CHECK: begin
          r_core_reset_n <= 1'b0;
          if (r_key_ok) begin
            r_found_key <= r_core_key;
            r_found     <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_HALT;
          end else if (r_core_key == LAST_K) begin
            r_exhausted <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_HALT;
          end else begin
            r_core_key <= r_core_key + 1'b1;
            r_rst_cnt  <= '0;
            r_state    <= S_CORE_RST;
          end
        end

        default: begin
          r_core_reset_n <= 1'b0;
          r_state        <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_search_ctrl.sv
// Self-checking bench for key_search_ctrl. Two controllers share clock and
// reset: A sweeps the full 10-bit range with a short watchdog, B sweeps only
// the top four keys. Each has a small behavioural decryption core model.
module tb_key_search_ctrl;

  localparam int KW = 10;

  typedef struct packed {
    logic          found;
    logic          exh;
    logic          tmo;
    logic [KW-1:0] key;
  } res_t;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;
  int   cyc     = 0;

  int checkCnt = 0;
  int passCnt  = 0;

  key_search_ctrl_if #(.KEY_W(KW)) ifA ();
  key_search_ctrl_if #(.KEY_W(KW)) ifB ();

  key_search_ctrl #(
    .KEY_W(KW), .KEY_FIRST(0), .KEY_LAST(1023), .RST_CYCLES(2), .TIMEOUT(16)
  ) dutA (
    .clk(clk), .reset_n(reset_n), .bus(ifA)
  );

  key_search_ctrl #(
    .KEY_W(KW), .KEY_FIRST('h3FC), .KEY_LAST('h3FF), .RST_CYCLES(2), .TIMEOUT(64)
  ) dutB (
    .clk(clk), .reset_n(reset_n), .bus(ifB)
  );

  // Free-running clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected outcomes and expected launch keys
  res_t          expQA[$];
  res_t          expQB[$];
  logic [KW-1:0] launchQA[$];
  logic [KW-1:0] launchQB[$];

  // Core model controls
  int acceptA = -1;
  int latA    = 3;
  bit noDoneA = 1'b0;
  int cntA    = 0;
  bit armedA  = 1'b0;
  int acceptB = -1;
  int latB    = 2;
  int cntB    = 0;
  bit armedB  = 1'b0;

  // Monitor state
  int            launchCntA = 0;
  int            launchCntB = 0;
  int            lastStartCycA = 0;
  int            lowRunA = 0;
  int            highRunA = 0;
  int            lastLowA = 0;
  int            stableA = 0;
  logic [KW-1:0] prevKeyA = '0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCnt++;
    assert (obs === exp) passCnt++;
    else $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  // Core model A: done a fixed latency after start, accepts only acceptA
  always @(negedge clk) begin
    if (!ifA.core_reset_n) begin
      ifA.core_done   = 1'b0;
      ifA.core_key_ok = 1'b0;
      armedA          = 1'b0;
    end else if (ifA.core_start) begin
      armedA = 1'b1;
      cntA   = latA;
    end else if (armedA && !noDoneA) begin
      if (cntA <= 1) begin
        ifA.core_done   = 1'b1;
        ifA.core_key_ok = (int'(ifA.core_key) == acceptA);
        armedA          = 1'b0;
      end else begin
        cntA--;
      end
    end
  end

  // Core model B: same behaviour, accepts only acceptB
  always @(negedge clk) begin
    if (!ifB.core_reset_n) begin
      ifB.core_done   = 1'b0;
      ifB.core_key_ok = 1'b0;
      armedB          = 1'b0;
    end else if (ifB.core_start) begin
      armedB = 1'b1;
      cntB   = latB;
    end else if (armedB) begin
      if (cntB <= 1) begin
        ifB.core_done   = 1'b1;
        ifB.core_key_ok = (int'(ifB.core_key) == acceptB);
        armedB          = 1'b0;
      end else begin
        cntB--;
      end
    end
  end

  // Launch monitor A: key order, core reset width, key stability, start timing
  always @(negedge clk) begin
    if (reset_n) begin
      if (!ifA.core_reset_n) begin
        lowRunA++;
        highRunA = 0;
      end else begin
        if (highRunA == 0) lastLowA = lowRunA;
        lowRunA = 0;
        highRunA++;
      end
      if (ifA.core_key == prevKeyA) stableA++;
      else stableA = 0;
      prevKeyA = ifA.core_key;
      if (ifA.core_start) begin
        launchCntA++;
        lastStartCycA = cyc;
        if (launchQA.size() > 0) checkOutput("A launch key", 32'(ifA.core_key), 32'(launchQA.pop_front()));
        else checkOutput("A launch expected", launchQA.size(), 1);
        if (ifA.core_key != '0) checkOutput("A core reset width", lastLowA, 2);
        else checkOutput("A core reset width min", 32'(lastLowA >= 2), 1);
        checkOutput("A key stable before start", 32'(stableA >= 3), 1);
        checkOutput("A start one cycle after release", highRunA, 2);
      end
    end
  end

  // Launch monitor B: key order only
  always @(negedge clk) begin
    if (reset_n && ifB.core_start) begin
      launchCntB++;
      if (launchQB.size() > 0) checkOutput("B launch key", 32'(ifB.core_key), 32'(launchQB.pop_front()));
      else checkOutput("B launch expected", launchQB.size(), 1);
    end
  end

  task automatic applyStimulus(input bit selB);
    @(negedge clk);
    if (selB) ifB.search_start = 1'b1;
    else      ifA.search_start = 1'b1;
    @(negedge clk);
    if (selB) ifB.search_start = 1'b0;
    else      ifA.search_start = 1'b0;
  endtask

  task automatic waitResult(input bit selB, input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (selB) done = !ifB.busy && (ifB.found || ifB.exhausted || ifB.timeout_err);
      else      done = !ifA.busy && (ifA.found || ifA.exhausted || ifA.timeout_err);
      if (done) break;
    end
    checkOutput(selB ? "B completes within budget" : "A completes within budget", 32'(done), 1);
  endtask

  task automatic scoreResult(input bit selB);
    res_t e;
    int   sz;
    logic f, x, t, b;
    logic [KW-1:0] k;
    sz = selB ? expQB.size() : expQA.size();
    if (sz == 0) begin
      checkOutput("scoreboard entry present", sz, 1);
      return;
    end
    if (selB) begin
      e = expQB.pop_front();
      f = ifB.found; x = ifB.exhausted; t = ifB.timeout_err; b = ifB.busy; k = ifB.found_key;
    end else begin
      e = expQA.pop_front();
      f = ifA.found; x = ifA.exhausted; t = ifA.timeout_err; b = ifA.busy; k = ifA.found_key;
    end
    checkOutput("result found", 32'(f), 32'(e.found));
    checkOutput("result exhausted", 32'(x), 32'(e.exh));
    checkOutput("result timeout_err", 32'(t), 32'(e.tmo));
    checkOutput("result busy", 32'(b), 0);
    if (e.found) checkOutput("result found_key", 32'(k), 32'(e.key));
  endtask

  task automatic checkResetState(input bit selB, input logic [KW-1:0] firstKey);
    logic rn, st, b;
    logic [2:0] fl;
    logic [KW-1:0] ck, fk;
    if (selB) begin
      rn = ifB.core_reset_n; st = ifB.core_start; b = ifB.busy;
      fl = {ifB.found, ifB.exhausted, ifB.timeout_err}; ck = ifB.core_key; fk = ifB.found_key;
    end else begin
      rn = ifA.core_reset_n; st = ifA.core_start; b = ifA.busy;
      fl = {ifA.found, ifA.exhausted, ifA.timeout_err}; ck = ifA.core_key; fk = ifA.found_key;
    end
    checkOutput("reset core_reset_n", 32'(rn), 0);
    checkOutput("reset core_start", 32'(st), 0);
    checkOutput("reset busy", 32'(b), 0);
    checkOutput("reset flags", 32'(fl), 0);
    checkOutput("reset core_key", 32'(ck), 32'(firstKey));
    checkOutput("reset found_key", 32'(fk), 0);
  endtask

  // Directed test sequence
  initial begin
    int base;
    ifA.search_start = 1'b0;
    ifB.search_start = 1'b0;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    $display("[TB] reset state");
    checkResetState(1'b0, 10'h000);
    checkResetState(1'b1, 10'h3FC);
    @(negedge clk) reset_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] search finds key 5, extra start edge mid-search ignored");
    acceptA = 5; latA = 3; base = launchCntA;
    for (int k = 0; k <= 5; k++) launchQA.push_back(KW'(k));
    expQA.push_back('{found: 1'b1, exh: 1'b0, tmo: 1'b0, key: 10'h005});
    applyStimulus(1'b0);
    checkOutput("A busy after start", 32'(ifA.busy), 1);
    repeat (8) @(negedge clk);
    applyStimulus(1'b0);
    waitResult(1'b0, 300);
    scoreResult(1'b0);
    checkOutput("A launches for key 5", launchCntA - base, 6);
    checkOutput("A launch queue drained", launchQA.size(), 0);

    $display("[TB] start held high, then re-pulsed after found");
    base = launchCntA;
    for (int k = 0; k <= 5; k++) launchQA.push_back(KW'(k));
    expQA.push_back('{found: 1'b1, exh: 1'b0, tmo: 1'b0, key: 10'h005});
    @(negedge clk) ifA.search_start = 1'b1;
    @(negedge clk);
    checkOutput("A found cleared on restart", 32'(ifA.found), 0);
    checkOutput("A busy on restart", 32'(ifA.busy), 1);
    waitResult(1'b0, 300);
    scoreResult(1'b0);
    repeat (20) @(negedge clk);
    checkOutput("A held start runs once", launchCntA - base, 6);
    checkOutput("A idle while start held", 32'(ifA.busy), 0);
    acceptA = 2; base = launchCntA;
    for (int k = 0; k <= 2; k++) launchQA.push_back(KW'(k));
    expQA.push_back('{found: 1'b1, exh: 1'b0, tmo: 1'b0, key: 10'h002});
    @(negedge clk) ifA.search_start = 1'b0;
    @(negedge clk) ifA.search_start = 1'b1;
    @(negedge clk);
    checkOutput("A found cleared on second search", 32'(ifA.found), 0);
    waitResult(1'b0, 300);
    scoreResult(1'b0);
    checkOutput("A launches for key 2", launchCntA - base, 3);
    ifA.search_start = 1'b0;

    $display("[TB] watchdog on a core that never finishes");
    noDoneA = 1'b1; base = launchCntA;
    launchQA.push_back(10'h000);
    expQA.push_back('{found: 1'b0, exh: 1'b0, tmo: 1'b1, key: 10'h000});
    applyStimulus(1'b0);
    waitResult(1'b0, 100);
    checkOutput("A timeout latency", cyc - lastStartCycA, 16);
    checkOutput("A core held in reset after timeout", 32'(ifA.core_reset_n), 0);
    scoreResult(1'b0);
    checkOutput("A single launch before timeout", launchCntA - base, 1);
    noDoneA = 1'b0;

    $display("[TB] top-of-range sweep without acceptance");
    acceptB = -1;
    for (int k = 'h3FC; k <= 'h3FF; k++) launchQB.push_back(KW'(k));
    expQB.push_back('{found: 1'b0, exh: 1'b1, tmo: 1'b0, key: 10'h000});
    applyStimulus(1'b1);
    waitResult(1'b1, 200);
    scoreResult(1'b1);
    checkOutput("B launches", launchCntB, 4);
    checkOutput("B core_key at last", 32'(ifB.core_key), 32'h3FF);
    repeat (5) @(negedge clk);
    checkOutput("B core_key no wrap", 32'(ifB.core_key), 32'h3FF);
    checkOutput("B exhausted holds", 32'(ifB.exhausted), 1);

    $display("[TB] async reset in the middle of a wait");
    acceptA = -1; latA = 10; base = launchCntA;
    launchQA.push_back(10'h000);
    launchQA.push_back(10'h001);
    applyStimulus(1'b0);
    for (int i = 0; i < 60 && launchCntA < base + 2; i++) @(negedge clk);
    checkOutput("A reached second key", launchCntA - base, 2);
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checkResetState(1'b0, 10'h000);
    checkResetState(1'b1, 10'h3FC);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("A no resume after reset", launchCntA - base, 2);
    checkOutput("A idle after reset", 32'(ifA.busy), 0);
    acceptA = 1; latA = 3; base = launchCntA;
    launchQA.push_back(10'h000);
    launchQA.push_back(10'h001);
    expQA.push_back('{found: 1'b1, exh: 1'b0, tmo: 1'b0, key: 10'h001});
    applyStimulus(1'b0);
    waitResult(1'b0, 200);
    scoreResult(1'b0);
    checkOutput("A restart launches", launchCntA - base, 2);

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
